// File: rtl/softmax_normalizer_if.sv
// Element stream into, and normalized fractions out of, the softmax normalizer.
// Ready is the only return path; there is no output backpressure.
interface softmax_normalizer_if #(
  parameter int BITWIDTH = 32
);
  logic                DataIn_vld;
  logic [BITWIDTH-1:0] DataIn;
  logic                Last;
  logic                Ready;
  logic                DataOut_vld;
  logic [BITWIDTH-1:0] DataOut;
  logic                Done;

  modport master (
    output DataIn_vld, DataIn, Last,
    input  Ready, DataOut_vld, DataOut, Done
  );

  modport slave (
    input  DataIn_vld, DataIn, Last,
    output Ready, DataOut_vld, DataOut, Done
  );
endinterface

// File: rtl/softmax_normalizer.sv
// Buffers one vector, sums it, then emits each element / sum as Q1.(BITWIDTH-1) via a restoring divider.
// Element i leaves BITWIDTH+1 cycles after element i-1 (first one after the last accept); Ready low outside LOAD, no output stall.
module softmax_normalizer #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8
) (
  input logic                  Clock,
  input logic                  Reset,
  softmax_normalizer_if.slave  io
);
  localparam int SUMW = BITWIDTH + $clog2(DEPTH);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = IW + 1;
  localparam int BCW  = $clog2(BITWIDTH);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]          state;
  logic [BITWIDTH-1:0] buffer [DEPTH];
  logic [CW-1:0]       count;
  logic [IW-1:0]       idx;
  logic [BCW-1:0]      bit_cnt;
  logic [SUMW-1:0]     sum;
  logic [SUMW:0]       rem;
  logic [BITWIDTH-1:0] quo;

  logic [SUMW:0] r_cur;
  logic [SUMW:0] r_sub;
  logic          q_bit;
  logic          accept;
  logic          load_end;
  logic          last_elem;

  always_comb begin
    accept    = (state == S_LOAD) && io.DataIn_vld;
    load_end  = accept && (io.Last || (count == CW'(DEPTH - 1)));
    // First iteration reads the element straight from the buffer, so no separate load cycle is needed.
    r_cur     = (bit_cnt == '0) ? (SUMW+1)'(buffer[idx]) : rem;
    q_bit     = (r_cur >= {1'b0, sum});
    r_sub     = q_bit ? (r_cur - {1'b0, sum}) : r_cur;
    last_elem = ({1'b0, idx} == (count - CW'(1)));
  end

  assign io.Ready = (state == S_LOAD);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= S_LOAD;
      count          <= '0;
      idx            <= '0;
      bit_cnt        <= '0;
      sum            <= '0;
      rem            <= '0;
      quo            <= '0;
      io.DataOut     <= '0;
      io.DataOut_vld <= 1'b0;
      io.Done        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      io.DataOut_vld <= 1'b0;
      io.Done        <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            buffer[count[IW-1:0]] <= io.DataIn;
            sum                   <= sum + SUMW'(io.DataIn);
            count                 <= count + CW'(1);
            if (load_end) begin
              state   <= S_DIV;
              idx     <= '0;
              bit_cnt <= '0;
            end
          end
        end
        S_DIV: begin
          rem     <= r_sub << 1;
          quo     <= {quo[BITWIDTH-2:0], q_bit};
          bit_cnt <= bit_cnt + BCW'(1);
          if (bit_cnt == BCW'(BITWIDTH - 1)) state <= S_EMIT;
        end
        S_EMIT: begin
          // An all-zero vector would otherwise yield all-ones quotients.
          io.DataOut     <= (sum == '0) ? '0 : quo;
          io.DataOut_vld <= 1'b1;
          bit_cnt        <= '0;
          if (last_elem) begin
            io.Done <= 1'b1;
            sum     <= '0;
            count   <= '0;
            idx     <= '0;
            state   <= S_LOAD;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_DIV;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed vectors for softmax_normalizer at BITWIDTH=16, DEPTH=4 (1.0 = 0x8000).
module tb_softmax_normalizer;
  logic Clock;
  logic Reset;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   stray_done;

  logic [15:0] out_q [$];
  int          t_q   [$];
  logic        done_q[$];

  softmax_normalizer_if #(.BITWIDTH(16)) io ();

  softmax_normalizer #(.BITWIDTH(16), .DEPTH(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .io    (io)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (io.DataOut_vld) begin
      out_q.push_back(io.DataOut);
      t_q.push_back(cyc);
      done_q.push_back(io.Done);
    end else if (io.Done) begin
      stray_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    t_q.delete();
    done_q.delete();
  endtask

  task automatic send(input logic [15:0] d, input logic l, output int e);
    io.DataIn_vld = 1'b1;
    io.DataIn     = d;
    io.Last       = l;
    @(posedge Clock);
    #1;
    e             = cyc;
    io.DataIn_vld = 1'b0;
    io.DataIn     = '0;
    io.Last       = 1'b0;
  endtask

  // Waits (bounded) for n pulses, idles to catch extras, then checks the count.
  task automatic wait_outs(input string tag, input int n);
    int k;
    k = 0;
    while (out_q.size() < n && k < 200) begin
      @(posedge Clock);
      k++;
    end
    repeat (20) @(posedge Clock);
    #1;
    chk({tag, "_count"}, out_q.size(), n);
  endtask

  task automatic chk_out(input string tag, input int i, input logic [15:0] v, input logic d);
    logic [15:0] ov;
    logic        od;
    ov = (i < out_q.size()) ? out_q[i] : 16'hxxxx;
    od = (i < done_q.size()) ? done_q[i] : 1'bx;
    chk($sformatf("%s_val%0d", tag, i), {16'h0, ov}, {16'h0, v});
    chk($sformatf("%s_done%0d", tag, i), {31'h0, od}, {31'h0, d});
  endtask

  initial begin
    int e;
    int e2;
    n_vec         = 0;
    n_err         = 0;
    stray_done    = 0;
    Reset         = 1'b1;
    io.DataIn_vld = 1'b0;
    io.DataIn     = '0;
    io.Last       = 1'b0;

    repeat (3) @(posedge Clock);
    #1;
    chk("rst_dout", {16'h0, io.DataOut}, 32'h0);
    chk("rst_vld",  {31'h0, io.DataOut_vld}, 32'h0);
    chk("rst_done", {31'h0, io.Done}, 32'h0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    chk("rst_ready", {31'h0, io.Ready}, 32'h1);

    // Basic vector 1,1,2,4 (sum 8)
    clear_q();
    send(16'd1, 1'b0, e);
    send(16'd1, 1'b0, e);
    send(16'd2, 1'b0, e);
    send(16'd4, 1'b1, e);
    chk("basic_ready_low", {31'h0, io.Ready}, 32'h0);
    wait_outs("basic", 4);
    chk_out("basic", 0, 16'h1000, 1'b0);
    chk_out("basic", 1, 16'h1000, 1'b0);
    chk_out("basic", 2, 16'h2000, 1'b0);
    chk_out("basic", 3, 16'h4000, 1'b1);
    chk("basic_lat0", (t_q.size() > 0) ? t_q[0] - e : -1, 17);
    chk("basic_gap1", (t_q.size() > 1) ? t_q[1] - t_q[0] : -1, 17);
    chk("basic_gap3", (t_q.size() > 3) ? t_q[3] - t_q[2] : -1, 17);
    chk("basic_ready_back", {31'h0, io.Ready}, 32'h1);

    // Single element
    clear_q();
    send(16'h0400, 1'b1, e);
    wait_outs("single", 1);
    chk_out("single", 0, 16'h8000, 1'b1);

    // Non-power-of-two sum: 1,2 (sum 3)
    clear_q();
    send(16'd1, 1'b0, e);
    send(16'd2, 1'b1, e);
    wait_outs("npow2", 2);
    chk_out("npow2", 0, 16'h2AAA, 1'b0);
    chk_out("npow2", 1, 16'h5555, 1'b1);

    // Zero vector
    clear_q();
    send(16'd0, 1'b0, e);
    send(16'd0, 1'b1, e);
    wait_outs("zero", 2);
    chk_out("zero", 0, 16'h0000, 1'b0);
    chk_out("zero", 1, 16'h0000, 1'b1);

    // DEPTH overflow: five back-to-back 8s without Last
    clear_q();
    io.DataIn_vld = 1'b1;
    io.DataIn     = 16'd8;
    io.Last       = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    e = cyc;
    chk("ovf_ready_low", {31'h0, io.Ready}, 32'h0);
    @(posedge Clock);
    #1;
    io.DataIn_vld = 1'b0;
    io.DataIn     = '0;
    wait_outs("ovf", 4);
    for (int i = 0; i < 4; i++) chk_out("ovf", i, 16'h2000, (i == 3));
    chk("ovf_lat0", (t_q.size() > 0) ? t_q[0] - e : -1, 17);

    // A leaked 5th element would turn this into a two-element vector
    clear_q();
    send(16'd2, 1'b1, e);
    wait_outs("post_ovf", 1);
    chk_out("post_ovf", 0, 16'h8000, 1'b1);

    // Reset in the middle of a divide
    clear_q();
    send(16'd3, 1'b0, e);
    send(16'd5, 1'b1, e);
    repeat (5) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_dout",  {16'h0, io.DataOut}, 32'h0);
    chk("mid_rst_vld",   {31'h0, io.DataOut_vld}, 32'h0);
    chk("mid_rst_ready", {31'h0, io.Ready}, 32'h1);
    clear_q();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    wait_outs("mid_rst_silent", 0);
    send(16'd2, 1'b1, e2);
    wait_outs("after_rst", 1);
    chk_out("after_rst", 0, 16'h8000, 1'b1);
    chk("after_rst_lat", (t_q.size() > 0) ? t_q[0] - e2 : -1, 17);

    chk("stray_done", stray_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/softmax_normalizer.md
# softmax_normalizer

Softmax normalization stage that sits directly downstream of the power-of-two `shifter`. It buffers one vector of exponent values (`2^k` words from the shifter) and accumulates their sum while loading. It then emits each element divided by that sum as an unsigned Q1.(BITWIDTH-1) fraction, using a sequential restoring divider at one quotient bit per cycle. There is no output backpressure: results are presented as one-cycle valid pulses.

## Interface
- `BITWIDTH`, 32: width of input words and of `DataOut`.
- `DEPTH`, 8: maximum vector length; buffer entries.
- `SUMW`, `BITWIDTH+$clog2(DEPTH)` (local): accumulator width; never overflows.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `DataIn_vld`  in  1  input element valid (connect to shifter `DataOut_vld`).
- `DataIn`  in  BITWIDTH  input element, unsigned (shifter `DataOut`).
- `Last`  in  1  marks final element of a vector; sampled only with an accepted element.
- `Ready`  out  1  high while the block accepts elements (LOAD state).
- `DataOut_vld`  out  1  one-cycle pulse per normalized element.
- `DataOut`  out  BITWIDTH  `floor(x * 2^(BITWIDTH-1) / sum)`; 1.0 = `2^(BITWIDTH-1)`.
- `Done`  out  1  one-cycle pulse with the final `DataOut_vld` of a vector.

## Operation
- States: LOAD, DIV, EMIT.
- Reset (async) sets state to LOAD and clears count, sum, element index, quotient and remainder. `DataOut`, `DataOut_vld` and `Done` are 0. `Ready` is 1 after reset release.
- LOAD, `Ready`=1:
  - Accept on `DataIn_vld & Ready`: `buf[count] <= DataIn`, `sum <= sum + DataIn`, `count <= count + 1`.
  - Go to DIV after accepting an element with `Last`=1, or after accepting the DEPTH-th element, whichever comes first. A forced end at DEPTH is treated as `Last`.
- Inputs with `Ready`=0 are ignored. They are not buffered and not summed.
- DIV, element `i`:
  - Load remainder `r = buf[i]` and clear the quotient.
  - Run BITWIDTH iterations, MSB quotient bit first. Each iteration: if `r >= sum`, set the quotient bit and `r -= sum`; then `r <<= 1`.
  - `r` is SUMW+1 bits wide. `x <= sum` guarantees the quotient fits in BITWIDTH bits.
- EMIT: register `DataOut <= quotient` and pulse `DataOut_vld`.
  - If `i` is the last index, also pulse `Done`, clear sum, count and `i`, and return to LOAD.
  - Otherwise increment `i` and return to DIV.
- `sum == 0` (all inputs zero): every iteration sets its bit because `r >= 0` holds. This case is overridden: `DataOut` is forced to 0 for every element of that vector. Output count and timing are unchanged.
- `DataOut` holds its last value between pulses. Consumers qualify it with `DataOut_vld`.

## Timing
- Edge E accepts the last element of a vector. Division iterations for element 0 occur on edges E+1 … E+BITWIDTH. Edge E+BITWIDTH+1 registers `DataOut`/`DataOut_vld`.
- Per-element period is BITWIDTH+1 cycles. Element `i` output is registered at edge E+(i+1)(BITWIDTH+1).
- Vector of N elements: `Done` is registered at edge E+N(BITWIDTH+1), concurrently with the final `DataOut_vld`. `Ready` is high in that same following cycle, so a new vector may begin immediately.
- `Ready` falls in the cycle after edge E. An element presented in the same cycle as the `Last` element's acceptance is not accepted unless it is that element.
- Reset asserted mid-DIV or mid-EMIT:
  - The vector is discarded immediately, with no further `DataOut_vld` or `Done`.
  - After release the block is in LOAD with an empty buffer.

## Test plan
Use BITWIDTH=16, DEPTH=4 for all scenarios; 1.0 = 0x8000.
- **Basic vector:** inputs 1, 1, 2, 4 with `Last` on 4 → outputs 0x1000, 0x1000, 0x2000, 0x4000. `Done` coincides with 0x4000. Consecutive pulses are 17 cycles apart, and the first pulse arrives 17 cycles after the last accept.
- **Single element:** 0x0400 with `Last` → single output 0x8000 with `Done`.
- **Non-power-of-two sum:** inputs 1, then 2 with `Last` → 0x2AAA (10922), then 0x5555 (21845).
- **DEPTH overflow:** 5 back-to-back elements 8, 8, 8, 8, 8, none with `Last` → 4 outputs of 0x2000. The 5th element is ignored because `Ready`=0 when it is presented.
- **Zero vector:** inputs 0, 0 with `Last` → two outputs of 0x0000, then `Done`.
- **Reset mid-divide:** assert `Reset` 5 cycles into DIV → outputs 0 immediately, and no `DataOut_vld`/`Done` follow. Loading 2 with `Last` after release → 0x8000.
